// File: rtl/reimu_shot_pool_pkg.sv
// Shared game constants and types for the player-shot pool.
// Playfield bounds are also used by the player-position block and the renderer.
package reimu_shot_pool_pkg;

    localparam int COORD_W = 10;
    localparam int Y_TOP   = 25;
    localparam int Y_BOT   = 465;
    localparam int X_MIN   = 24;
    localparam int X_MAX   = 430;

    typedef logic [COORD_W-1:0] coord_t;

    // One pool slot: active flag plus position.
    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
    } shot_t;

    // Spawn height above the player, saturating at the playfield top.
    // The compare is widened by one bit so top+dy cannot wrap.
    function automatic coord_t calc_spawn_y(coord_t py, coord_t dy, coord_t top);
        logic [COORD_W:0] lim;
        lim = {1'b0, top} + {1'b0, dy};
        return ({1'b0, py} >= lim) ? coord_t'(py - dy) : top;
    endfunction

endpackage

// File: rtl/reimu_shot_pool_if.sv
// Shot-pool bus: player/fire/collision inputs in, flat shot pool out.
//   master: drives gamestart, fire, reimux, reimuy, hit_valid, hit_idx
//   slave : the pool itself; drives shot_valid, shot_x, shot_y, shot_drop
interface reimu_shot_pool_if #(
    parameter int NSHOT = 8
);
    import reimu_shot_pool_pkg::*;

    localparam int IDXW = (NSHOT > 1) ? $clog2(NSHOT) : 1;

    logic                     gamestart;
    logic                     fire;
    coord_t                   reimux;
    coord_t                   reimuy;
    logic                     hit_valid;
    logic [IDXW-1:0]          hit_idx;
    logic [NSHOT-1:0]         shot_valid;
    logic [NSHOT*COORD_W-1:0] shot_x;
    logic [NSHOT*COORD_W-1:0] shot_y;
    logic                     shot_drop;

    modport master (
        output gamestart, fire, reimux, reimuy, hit_valid, hit_idx,
        input  shot_valid, shot_x, shot_y, shot_drop
    );

    modport slave (
        input  gamestart, fire, reimux, reimuy, hit_valid, hit_idx,
        output shot_valid, shot_x, shot_y, shot_drop
    );

endinterface

// File: rtl/reimu_shot_pool_alloc.sv
// Lowest-index free-slot priority encoder (combinational).
//   free_mask in  : 1 = slot free
//   free_any  out : at least one slot free
//   free_idx  out : lowest free slot index (0 when none free)
module reimu_shot_alloc
    import reimu_shot_pool_pkg::*;
#(
    parameter int NSHOT = 8,
    parameter int IDXW  = 3
) (
    input  logic [NSHOT-1:0] free_mask,
    output logic             free_any,
    output logic [IDXW-1:0]  free_idx
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        free_any = |free_mask;
        free_idx = '0;
        for (int i = NSHOT - 1; i >= 0; i--) begin
            if (free_mask[i]) free_idx = IDXW'(i);
        end
    end

endmodule

// File: rtl/reimu_shot_pool.sv
// Player-shot manager: spawns shots above the player on fire, moves them up
// SHOT_SPEED per tick, retires them at the top or on a collision hit.
//   clk22 : game tick clock
//   rst   : synchronous active-high reset (bus.gamestart has the same effect)
//   bus   : slave side of reimu_shot_pool_if (inputs + flat shot pool out)
module reimu_shot_pool #(
    parameter int NSHOT       = 8,
    parameter int SHOT_SPEED  = 12,
    parameter int FIRE_PERIOD = 4,
    parameter int SPAWN_DY    = 16,
    parameter int Y_TOP       = reimu_shot_pool_pkg::Y_TOP
) (
    input  logic             clk22,
    input  logic             rst,
    reimu_shot_pool_if.slave bus
);
    import reimu_shot_pool_pkg::*;

    localparam int     IDXW      = (NSHOT > 1) ? $clog2(NSHOT) : 1;
    localparam int     CDW       = $clog2(FIRE_PERIOD) + 1;
    localparam coord_t RETIRE_Y  = coord_t'(Y_TOP + SHOT_SPEED);
    localparam coord_t SPEED_C   = coord_t'(SHOT_SPEED);
    localparam coord_t DY_C      = coord_t'(SPAWN_DY);
    localparam coord_t TOP_C     = coord_t'(Y_TOP);
    localparam logic [CDW-1:0] CD_RELOAD = CDW'(FIRE_PERIOD - 1);

    logic               clr;
    logic [NSHOT-1:0]   valid_q;
    logic               free_any;
    logic [IDXW-1:0]    free_idx;
    logic               want;
    logic               spawn;
    coord_t             spawn_y;
    logic [CDW-1:0]     cooldown;
    logic               drop_q;

    assign clr     = rst | bus.gamestart;
    assign want    = bus.fire && (cooldown == '0);
    // Search uses registered valids only, so same-cycle frees are not reused.
    assign spawn   = want && free_any;
    assign spawn_y = calc_spawn_y(bus.reimuy, DY_C, TOP_C);

    reimu_shot_alloc #(
        .NSHOT (NSHOT),
        .IDXW  (IDXW)
    ) u_alloc (
        .free_mask (~valid_q),
        .free_any  (free_any),
        .free_idx  (free_idx)
    );

    // A full pool leaves cooldown at 0 so the spawn goes out the first
    // cycle a slot frees up.
    always_ff @(posedge clk22) begin
        if (clr) begin
            cooldown <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= want && !free_any;
            if (spawn)                cooldown <= CD_RELOAD;
            else if (cooldown != '0)  cooldown <= cooldown - 1'b1;
        end
    end

    assign bus.shot_drop = drop_q;

    for (genvar i = 0; i < NSHOT; i++) begin : g_slot
        shot_t s;

        always_ff @(posedge clk22) begin
            if (clr) begin
                s <= '0;
            end else if (s.valid) begin
                // Retire compare precedes the subtract, so y never wraps.
                if (bus.hit_valid && bus.hit_idx == IDXW'(i)) s.valid <= 1'b0;
                else if (s.y <= RETIRE_Y)                     s.valid <= 1'b0;
                else                                          s.y     <= s.y - SPEED_C;
            end else if (spawn && free_idx == IDXW'(i)) begin
                s.valid <= 1'b1;
                s.x     <= bus.reimux;
                s.y     <= spawn_y;
            end
        end

        assign valid_q[i]                       = s.valid;
        assign bus.shot_x[i*COORD_W +: COORD_W] = s.x;
        assign bus.shot_y[i*COORD_W +: COORD_W] = s.y;
    end

    assign bus.shot_valid = valid_q;

endmodule

// File: tb/tb_reimu_shot_pool.sv
module tb_reimu_shot_pool;

    localparam int SPD = 12;
    localparam int FP  = 4;
    localparam int DY  = 16;
    localparam int YT  = 25;

    logic clk22 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk22 = ~clk22;

    reimu_shot_pool_if #(.NSHOT(8)) bus ();
    reimu_shot_pool_if #(.NSHOT(8)) bf ();

    reimu_shot_pool u_dut (
        .clk22 (clk22),
        .rst   (rst),
        .bus   (bus)
    );

    reimu_shot_pool #(
        .NSHOT       (8),
        .SHOT_SPEED  (1),
        .FIRE_PERIOD (1)
    ) u_fast (
        .clk22 (clk22),
        .rst   (rst),
        .bus   (bf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk22);
        #1;
    endtask

    function automatic int gx(int i);
        return int'(bus.shot_x[i*10 +: 10]);
    endfunction
    function automatic int gy(int i);
        return int'(bus.shot_y[i*10 +: 10]);
    endfunction

    // Behavioural reference: slot list, cooldown counter, drop flag.
    bit mv[8];
    int mx[8];
    int my[8];
    int mcd;
    bit mdrop;

    task automatic model_step(bit clr, bit f, int px, int py, bit hv, int hi);
        int fi;
        bit want;
        if (clr) begin
            for (int i = 0; i < 8; i++) begin mv[i] = 0; mx[i] = 0; my[i] = 0; end
            mcd = 0; mdrop = 0;
            return;
        end
        fi = -1;
        for (int i = 0; i < 8; i++) if (!mv[i] && fi < 0) fi = i;
        want = f && (mcd == 0);
        for (int i = 0; i < 8; i++) begin
            if (mv[i]) begin
                if (hv && hi == i)        mv[i] = 0;
                else if (my[i] <= YT+SPD) mv[i] = 0;
                else                      my[i] = my[i] - SPD;
            end
        end
        mdrop = want && (fi < 0);
        if (want && fi >= 0) begin
            mv[fi] = 1; mx[fi] = px;
            my[fi] = (py >= YT + DY) ? py - DY : YT;
            mcd = FP - 1;
        end else if (mcd > 0) begin
            mcd--;
        end
    endtask

    typedef struct {
        bit r; bit f; int px; int py; bit hv; int hi;
        int ev; bit ed; int cs; int ex; int ey;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] mvv;
        logic [79:0] mxv, myv;
        int exp_y;
        bit done;

        bus.gamestart = 0; bus.fire = 0; bus.reimux = 0; bus.reimuy = 0;
        bus.hit_valid = 0; bus.hit_idx = 0;
        bf.gamestart = 0; bf.fire = 0; bf.reimux = 0; bf.reimuy = 0;
        bf.hit_valid = 0; bf.hit_idx = 0;

        //          r  f  px   py   hv hi  ev  ed cs  ex   ey
        tbl[0]  = '{1, 1, 220, 360, 0, 0,  0,  0, 0,  0,   0};
        tbl[1]  = '{1, 1, 220, 360, 0, 0,  0,  0, 0,  0,   0};
        tbl[2]  = '{1, 1, 220, 360, 0, 0,  0,  0, 0,  0,   0};
        tbl[3]  = '{0, 1, 220, 360, 0, 0,  1,  0, 0,  220, 344};
        tbl[4]  = '{0, 0, 220, 360, 0, 0,  1,  0, 0,  220, 332};
        tbl[5]  = '{0, 0, 220, 360, 0, 0,  1,  0, 0,  220, 320};
        tbl[6]  = '{0, 0, 220, 360, 0, 0,  1,  0, 0,  220, 308};
        tbl[7]  = '{0, 1, 100, 25,  0, 0,  3,  0, 1,  100, 25};
        tbl[8]  = '{0, 0, 100, 25,  1, 0,  0,  0, 1,  100, 25};
        tbl[9]  = '{0, 1, 100, 25,  0, 0,  0,  0, 1,  100, 25};
        tbl[10] = '{0, 1, 100, 25,  0, 0,  0,  0, 1,  100, 25};
        tbl[11] = '{0, 1, 50,  41,  0, 0,  1,  0, 0,  50,  25};
        tbl[12] = '{0, 0, 50,  41,  1, 5,  0,  0, 0,  50,  25};

        for (int k = 0; k < 13; k++) begin
            rst = tbl[k].r; bus.fire = tbl[k].f;
            bus.reimux = 10'(tbl[k].px); bus.reimuy = 10'(tbl[k].py);
            bus.hit_valid = tbl[k].hv; bus.hit_idx = 3'(tbl[k].hi);
            tick();
            chk($sformatf("tbl%0d valid", k), 80'(bus.shot_valid), 80'(tbl[k].ev));
            chk($sformatf("tbl%0d drop", k), 80'(bus.shot_drop), 80'(tbl[k].ed));
            chk($sformatf("tbl%0d x", k), 80'(gx(tbl[k].cs)), 80'(tbl[k].ex));
            chk($sformatf("tbl%0d y", k), 80'(gy(tbl[k].cs)), 80'(tbl[k].ey));
            if (k == 2) begin
                chk("reset all x", 80'(bus.shot_x), 80'(0));
                chk("reset all y", 80'(bus.shot_y), 80'(0));
            end
        end
        bus.hit_valid = 0;

        // Full flight of a single shot to retirement.
        rst = 1; bus.fire = 0; tick();
        rst = 0; bus.fire = 1; bus.reimux = 220; bus.reimuy = 360; tick();
        bus.fire = 0;
        exp_y = 344;
        chk("flight spawn y", 80'(gy(0)), 80'(exp_y));
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            tick();
            if (exp_y <= YT + SPD) begin
                chk("flight retire", 80'(bus.shot_valid), 80'(0));
                done = 1;
            end else begin
                exp_y -= SPD;
                chk("flight valid", 80'(bus.shot_valid[0]), 80'(1));
                chk("flight y", 80'(gy(0)), 80'(exp_y));
            end
        end
        if (!done) chk("flight timeout", 80'(0), 80'(1));

        // Steady-fire cadence.
        rst = 1; tick();
        rst = 0; bus.fire = 1; bus.reimux = 200; bus.reimuy = 360;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("cadence%0d valid", k), 80'(bus.shot_valid), 80'((1 << (k/4 + 1)) - 1));
            chk($sformatf("cadence%0d drop", k), 80'(bus.shot_drop), 80'(0));
        end

        // gamestart mid-flight with five shots active.
        bus.gamestart = 1; tick();
        chk("gamestart valid", 80'(bus.shot_valid), 80'(0));
        chk("gamestart x", 80'(bus.shot_x), 80'(0));
        chk("gamestart y", 80'(bus.shot_y), 80'(0));
        bus.gamestart = 0; tick();
        chk("post gamestart spawn", 80'(bus.shot_valid), 80'(1));
        bus.fire = 0;

        // Full pool on the fast instance.
        rst = 1; tick();
        rst = 0; bf.fire = 1; bf.reimux = 10; bf.reimuy = 400;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("fill%0d valid", k), 80'(bf.shot_valid), 80'((1 << (k + 1)) - 1));
            chk($sformatf("fill%0d drop", k), 80'(bf.shot_drop), 80'(0));
        end
        tick();
        chk("full drop", 80'(bf.shot_drop), 80'(1));
        chk("full valid", 80'(bf.shot_valid), 80'(8'hff));
        bf.hit_valid = 1; bf.hit_idx = 3; tick();
        bf.hit_valid = 0;
        chk("hit slot3 valid", 80'(bf.shot_valid), 80'(8'hf7));
        chk("hit slot3 drop", 80'(bf.shot_drop), 80'(1));
        tick();
        chk("refill valid", 80'(bf.shot_valid), 80'(8'hff));
        chk("refill drop", 80'(bf.shot_drop), 80'(0));
        chk("refill y", 80'(bf.shot_y[30 +: 10]), 80'(384));
        chk("refill x", 80'(bf.shot_x[30 +: 10]), 80'(10));
        bf.fire = 0;

        // Randomized run against the reference model.
        rst = 1; model_step(1, 0, 0, 0, 0, 0); tick();
        rst = 0;
        for (int c = 0; c < 600; c++) begin
            bus.gamestart = ($urandom_range(0, 63) == 0);
            bus.fire      = ($urandom_range(0, 3) != 0);
            bus.reimux    = 10'($urandom_range(0, 1023));
            bus.reimuy    = 10'($urandom_range(0, 479));
            bus.hit_valid = ($urandom_range(0, 3) == 0);
            bus.hit_idx   = 3'($urandom_range(0, 7));
            model_step(bus.gamestart, bus.fire, int'(bus.reimux), int'(bus.reimuy),
                       bus.hit_valid, int'(bus.hit_idx));
            tick();
            for (int i = 0; i < 8; i++) begin
                mvv[i] = mv[i];
                mxv[i*10 +: 10] = 10'(mx[i]);
                myv[i*10 +: 10] = 10'(my[i]);
            end
            chk($sformatf("rand%0d valid", c), 80'(bus.shot_valid), 80'(mvv));
            chk($sformatf("rand%0d x", c), bus.shot_x, mxv);
            chk($sformatf("rand%0d y", c), bus.shot_y, myv);
            chk($sformatf("rand%0d drop", c), 80'(bus.shot_drop), 80'(mdrop));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
